// File: rtl/alp_pkg.sv
// Shared definitions for the ALP controller front-end: opcodes, sequencer
// state encoding and the default multiply COMP window length.
package alp_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // 1 start + 3*W worst-case Booth steps + 1 end, for W=4
    localparam int DEFAULT_MUL_CYCLES = 14;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_CAPT  = 3'd3,
        S_RESP  = 3'd4,
        S_CLEAR = 3'd5
    } seq_state_t;

    function automatic int comp_cycles(input logic [2:0] op, input int mul_cycles);
        return (op == OP_MUL) ? mul_cycles : 1;
    endfunction

endpackage

// File: rtl/alp_cmd_fifo.sv
// Small synchronous show-ahead FIFO for queued sequencer commands.
// A push while full is dropped, even if a pop happens in the same cycle.
module alp_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alp_cmd_sequencer.sv
// Command front-end driving LOAD/COMP/CLR of the ALP controller and returning results.
// Define ALP_SEQ_CMD_FIFO_EN to buffer commands in an alp_cmd_fifo instance.
module alp_cmd_sequencer
    import alp_pkg::*;
#(
    parameter int W          = 4,
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_clr,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         alp_load,
    output logic         alp_comp,
    output logic         alp_clr,
    output logic [2:0]   alp_op,
    output logic [W-1:0] alp_data_a,
    output logic [W-1:0] alp_data_b,
    input  logic [W-1:0] r0_in,
    input  logic [W-1:0] r1_in,
    input  logic         err_in,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_lo,
    output logic [W-1:0] rsp_hi,
    output logic         rsp_err,
    output logic         busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             head_valid;
    logic             head_clr;
    logic [2:0]       head_op;
    logic [W-1:0]     head_a;
    logic [W-1:0]     head_b;
    logic             take;

    assign take = (state == S_IDLE) && head_valid;

`ifdef ALP_SEQ_CMD_FIFO_EN
    localparam int ENTRY_W = 1 + 3 + 2 * W;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    assign cmd_ready  = !fifo_full;
    assign head_valid = !fifo_empty;
    assign {head_clr, head_op, head_a, head_b} = fifo_head;

    alp_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && !fifo_full),
        .push_data ({cmd_clr, cmd_op, cmd_a, cmd_b}),
        .pop       (take),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    logic ready_q;

    assign cmd_ready  = ready_q;
    assign head_valid = cmd_valid && ready_q;
    assign head_clr   = cmd_clr;
    assign head_op    = cmd_op;
    assign head_a     = cmd_a;
    assign head_b     = cmd_b;

    // Ready mirrors "next state is IDLE" so it is high exactly while IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end else if (take) begin
            ready_q <= 1'b0;
        end else if ((state == S_RESP && rsp_ready) || state == S_CLEAR) begin
            ready_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            alp_load   <= 1'b0;
            alp_comp   <= 1'b0;
            alp_clr    <= 1'b0;
            alp_op     <= '0;
            alp_data_a <= '0;
            alp_data_b <= '0;
            rsp_valid  <= 1'b0;
            rsp_lo     <= '0;
            rsp_hi     <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            alp_load <= 1'b0;
            alp_clr  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        busy <= 1'b1;
                        if (head_clr) begin
                            state   <= S_CLEAR;
                            alp_clr <= 1'b1;
                        end else begin
                            state      <= S_LOAD;
                            alp_load   <= 1'b1;
                            alp_op     <= head_op;
                            alp_data_a <= head_a;
                            alp_data_b <= head_b;
                            cnt        <= CNT_W'(comp_cycles(head_op, MUL_CYCLES) - 1);
                        end
                    end
                end
                S_LOAD: begin
                    state    <= S_EXEC;
                    alp_comp <= 1'b1;
                end
                // Counter holds remaining COMP cycles after the current one.
                S_EXEC: begin
                    if (cnt == '0) begin
                        state    <= S_CAPT;
                        alp_comp <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_CAPT: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_lo    <= r0_in;
                    rsp_hi    <= (alp_op == OP_MUL) ? r1_in : '0;
                    rsp_err   <= err_in;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    alp_comp <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alp_cmd_sequencer.sv
// Self-checking bench for alp_cmd_sequencer (default build, no command FIFO).
// Expected timing and results come from a per-command model of the handshake rules.
module tb_alp_cmd_sequencer;

    localparam int W          = 4;
    localparam int MUL_CYCLES = 14;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic         cmd_clr;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         alp_load;
    logic         alp_comp;
    logic         alp_clr;
    logic [2:0]   alp_op;
    logic [W-1:0] alp_data_a;
    logic [W-1:0] alp_data_b;
    logic [W-1:0] r0_in;
    logic [W-1:0] r1_in;
    logic         err_in;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_lo;
    logic [W-1:0] rsp_hi;
    logic         rsp_err;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    alp_cmd_sequencer #(
        .W          (W),
        .MUL_CYCLES (MUL_CYCLES),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_clr    (cmd_clr),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alp_load   (alp_load),
        .alp_comp   (alp_comp),
        .alp_clr    (alp_clr),
        .alp_op     (alp_op),
        .alp_data_a (alp_data_a),
        .alp_data_b (alp_data_b),
        .r0_in      (r0_in),
        .r1_in      (r1_in),
        .err_in     (err_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a command from a falling edge and returns just after the accepting edge.
    task automatic apply_stimulus(input logic clr, input logic [2:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_clr   = clr;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            check_output("accept_timeout", 32'(cmd_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r0, input logic [W-1:0] r1, input logic err,
                           input int stall);
        int n, last;
        int load_cnt, first_load, comp_cnt, first_comp, last_comp, rsp_cnt, first_rsp;
        int excl_bad, op_bad, busy_bad, unstable;
        logic [W-1:0] load_a, load_b, got_lo, got_hi, exp_hi;
        logic got_err;
        n          = (op == 3'b010) ? MUL_CYCLES : 1;
        last       = n + 4 + stall;
        exp_hi     = (op == 3'b010) ? r1 : '0;
        load_cnt   = 0; first_load = -1;
        comp_cnt   = 0; first_comp = -1; last_comp = -1;
        rsp_cnt    = 0; first_rsp  = -1;
        excl_bad   = 0; op_bad = 0; busy_bad = 0; unstable = 0;
        load_a     = '0; load_b = '0; got_lo = '0; got_hi = '0; got_err = 1'b0;
        r0_in      = r0;
        r1_in      = r1;
        err_in     = err;
        rsp_ready  = 1'b0;
        apply_stimulus(1'b0, op, a, b);
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            if (int'(alp_load) + int'(alp_comp) + int'(alp_clr) > 1) excl_bad++;
            if (alp_load) begin
                load_cnt++;
                if (first_load < 0) first_load = cyc;
                load_a = alp_data_a;
                load_b = alp_data_b;
            end
            if (alp_comp) begin
                comp_cnt++;
                if (first_comp < 0) first_comp = cyc;
                last_comp = cyc;
                if (alp_op !== op) op_bad++;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (first_rsp < 0) begin
                    first_rsp = cyc;
                    got_lo    = rsp_lo;
                    got_hi    = rsp_hi;
                    got_err   = rsp_err;
                end else if ({rsp_lo, rsp_hi, rsp_err} !== {got_lo, got_hi, got_err}) begin
                    unstable++;
                end
            end
            if (busy !== (cyc < last)) busy_bad++;
            rsp_ready = (cyc >= n + 3 + stall);
        end
        rsp_ready = 1'b0;
        check_output("load_count",     32'(load_cnt),   32'd1);
        check_output("load_cycle",     32'(first_load), 32'd1);
        check_output("load_data_a",    32'(load_a),     32'(a));
        check_output("load_data_b",    32'(load_b),     32'(b));
        check_output("comp_count",     32'(comp_cnt),   32'(n));
        check_output("comp_first",     32'(first_comp), 32'd2);
        check_output("comp_last",      32'(last_comp),  32'(n + 1));
        check_output("comp_op",        32'(op_bad),     32'd0);
        check_output("strobe_excl",    32'(excl_bad),   32'd0);
        check_output("rsp_valid_cyc",  32'(first_rsp),  32'(n + 3));
        check_output("rsp_valid_len",  32'(rsp_cnt),    32'(stall + 1));
        check_output("rsp_lo",         32'(got_lo),     32'(r0));
        check_output("rsp_hi",         32'(got_hi),     32'(exp_hi));
        check_output("rsp_err",        32'(got_err),    32'(err));
        check_output("rsp_stable",     32'(unstable),   32'd0);
        check_output("busy_window",    32'(busy_bad),   32'd0);
        check_output("ready_after",    32'(cmd_ready),  32'd1);
    endtask

    task automatic run_clear();
        int clr_cnt, first_clr, other_cnt;
        logic busy_c1, busy_c2, ready_c2;
        clr_cnt = 0; first_clr = -1; other_cnt = 0;
        busy_c1 = 1'b0; busy_c2 = 1'b1; ready_c2 = 1'b0;
        apply_stimulus(1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (alp_clr) begin
                clr_cnt++;
                if (first_clr < 0) first_clr = cyc;
            end
            if (alp_load || alp_comp || rsp_valid) other_cnt++;
            if (cyc == 1) busy_c1 = busy;
            if (cyc == 2) begin
                busy_c2  = busy;
                ready_c2 = cmd_ready;
            end
        end
        check_output("clr_count",    32'(clr_cnt),   32'd1);
        check_output("clr_cycle",    32'(first_clr), 32'd1);
        check_output("clr_no_other", 32'(other_cnt), 32'd0);
        check_output("clr_busy_c1",  32'(busy_c1),   32'd1);
        check_output("clr_busy_c2",  32'(busy_c2),   32'd0);
        check_output("clr_ready_c2", 32'(ready_c2),  32'd1);
    endtask

    task automatic run_reset_mid_mul();
        int stale;
        stale     = 0;
        r0_in     = 4'hA;
        r1_in     = 4'h5;
        err_in    = 1'b1;
        rsp_ready = 1'b1;
        apply_stimulus(1'b0, 3'b010, 4'h3, 4'h5);
        repeat (7) @(negedge clk);
        check_output("rst_pre_comp", 32'(alp_comp), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("rst_outputs_zero",
                     32'({alp_load, alp_comp, alp_clr, alp_op, alp_data_a, alp_data_b,
                          rsp_valid, rsp_lo, rsp_hi, rsp_err, busy}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (rsp_valid || busy || alp_load || alp_comp || alp_clr) stale++;
        end
        rsp_ready = 1'b0;
        check_output("rst_no_stale",    32'(stale),     32'd0);
        check_output("rst_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        r0_in     = '0;
        r1_in     = '0;
        err_in    = 1'b0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_outputs",
                     32'({alp_load, alp_comp, alp_clr, alp_op, alp_data_a, alp_data_b,
                          rsp_valid, rsp_lo, rsp_hi, rsp_err, busy}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_ready", 32'(cmd_ready), 32'd1);

        $display("[TB] ALU op and multiply");
        run_cmd(3'b000, 4'd3, 4'd2, 4'd5, 4'd9, 1'b0, 0);
        run_cmd(3'b010, 4'd3, 4'd5, 4'd15, 4'd0, 1'b0, 0);

        $display("[TB] response backpressure");
        run_cmd(3'b011, 4'd9, 4'd4, 4'd12, 4'd7, 1'b0, 10);

        $display("[TB] clear");
        run_clear();

        $display("[TB] error pass-through");
        run_cmd(3'b001, 4'd7, 4'd1, 4'd6, 4'd9, 1'b1, 0);
        run_cmd(3'b001, 4'd7, 4'd1, 4'd6, 4'd9, 1'b0, 0);

        $display("[TB] randomized commands");
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                run_clear();
            end else begin
                run_cmd(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                        W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
            end
        end
        run_cmd(3'b010, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 2);

        $display("[TB] reset during multiply");
        run_reset_mid_mul();
        run_cmd(3'b100, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
